// File: rtl/fuzzy_bus_master.sv
// Initiator for the 8-bit MMIO bus. It turns write/read/poll commands into timed cs/rd/wr cycles.
// Optional write read-back check is enabled by defining FUZZY_BM_WRVERIFY_EN.
module fuzzy_bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 1,
    parameter int HOLD_CYC   = 1,
    parameter int POLL_GAP   = 4,
    parameter int POLL_MAX   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_data,
    input  logic [7:0] cmd_mask,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic [7:0] addr,
    output logic [7:0] wdata,
    input  logic [7:0] rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_GAP,
        S_RESP
    } state_t;

    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_POLL = 2'b10;

    localparam logic [7:0] SETUP_LAST  = 8'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [7:0] STROBE_LAST = 8'((STROBE_CYC > 0) ? STROBE_CYC - 1 : 0);
    localparam logic [7:0] HOLD_LAST   = 8'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [7:0] GAP_LAST    = 8'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [7:0] POLL_LIMIT  = 8'(POLL_MAX);

    // An access with no setup phase starts directly with the strobe.
    function automatic state_t entry_state();
        return (SETUP_CYC > 0) ? S_SETUP : S_STROBE;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] attempts_q, attempts_d;
    logic [1:0] op_q, op_d;
    logic [7:0] addr_lat_q, addr_lat_d;
    logic [7:0] data_q, data_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] sample_q, sample_d;
    logic       verify_q, verify_d;

    logic       cmd_ready_q, cmd_ready_d;
    logic       busy_q, busy_d;
    logic       cs_q, cs_d;
    logic       rd_q, rd_d;
    logic       wr_q, wr_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_err_q, rsp_err_d;

    logic       access_done;
    logic [7:0] cur_sample;
    logic       reading_d;
    logic       in_access_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        attempts_d  = attempts_q;
        op_d        = op_q;
        addr_lat_d  = addr_lat_q;
        data_d      = data_q;
        mask_d      = mask_q;
        sample_d    = sample_q;
        verify_d    = verify_q;
        rsp_data_d  = 8'h00;
        rsp_err_d   = 1'b0;
        access_done = 1'b0;
        // With no hold phase the decision is made in the last strobe cycle, before the sample is registered.
        cur_sample  = (state_q == S_STROBE) ? rdata : sample_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d       = cmd_op;
                    addr_lat_d = cmd_addr;
                    data_d     = cmd_data;
                    mask_d     = cmd_mask;
                    attempts_d = 8'd0;
                    cnt_d      = 8'd0;
                    verify_d   = 1'b0;
                    if (cmd_op == 2'b11) begin
                        state_d   = S_RESP;
                        rsp_err_d = 1'b1;
                    end else begin
                        state_d = entry_state();
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_STROBE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    sample_d = rdata;
                    cnt_d    = 8'd0;
                    if (HOLD_CYC > 0) begin
                        state_d = S_HOLD;
                    end else begin
                        access_done = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    access_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = entry_state();
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (access_done) begin
            cnt_d = 8'd0;
            case (op_q)
                OP_WR: begin
`ifdef FUZZY_BM_WRVERIFY_EN
                    if (!verify_q) begin
                        verify_d = 1'b1;
                        state_d  = entry_state();
                    end else begin
                        state_d    = S_RESP;
                        rsp_data_d = cur_sample;
                        rsp_err_d  = (cur_sample != data_q);
                    end
`else
                    state_d = S_RESP;
`endif
                end
                OP_RD: begin
                    state_d    = S_RESP;
                    rsp_data_d = cur_sample;
                end
                OP_POLL: begin
                    attempts_d = attempts_q + 8'd1;
                    if ((cur_sample & mask_q) == (data_q & mask_q)) begin
                        state_d    = S_RESP;
                        rsp_data_d = cur_sample;
                    end else if (attempts_d == POLL_LIMIT) begin
                        state_d    = S_RESP;
                        rsp_data_d = cur_sample;
                        rsp_err_d  = 1'b1;
                    end else begin
                        state_d = S_GAP;
                    end
                end
                default: begin
                    state_d   = S_RESP;
                    rsp_err_d = 1'b1;
                end
            endcase
        end

        // Bus outputs are decoded from the next state so that every output is a flop.
`ifdef FUZZY_BM_WRVERIFY_EN
        reading_d = (op_d != OP_WR) || verify_d;
`else
        reading_d = (op_d != OP_WR);
`endif
        in_access_d = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        cs_d        = in_access_d;
        rd_d        = (state_d == S_STROBE) && reading_d;
        wr_d        = (state_d == S_STROBE) && !reading_d;
        addr_d      = (in_access_d || state_d == S_GAP) ? addr_lat_d : 8'h00;
        wdata_d     = (in_access_d && op_d == OP_WR) ? data_d : 8'h00;
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            attempts_q  <= 8'd0;
            verify_q    <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            cs_q        <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            attempts_q  <= attempts_d;
            verify_q    <= verify_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            cs_q        <= cs_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Command fields and the read sample are only consumed under state control, so they are not reset.
    always_ff @(posedge clk) begin
        op_q       <= op_d;
        addr_lat_q <= addr_lat_d;
        data_q     <= data_d;
        mask_q     <= mask_d;
        sample_q   <= sample_d;
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign cs        = cs_q;
    assign rd        = rd_q;
    assign wr        = wr_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/fuzzy_bus_master.md
Name: fuzzy_bus_master

Overview:
- Initiator side of the 8-bit MCU MMIO bus (cs/rd/wr/addr/wdata/rdata) that the fuzzy coprocessor's shadow-register front end responds to.
- Accepts single commands (write, read, poll-until-match) on a valid/ready interface.
- Turns each command into timed bus cycles and returns one response per command.
- Used in bench/FPGA bring-up to drive the coprocessor without a real MCU: load parameters, write T_in/dT_in, start, poll status, read G_out.

Parameters:
- SETUP_CYC, 1, cycles cs+addr held before strobe (0 allowed).
- STROBE_CYC, 1, cycles rd/wr held high (min 1).
- HOLD_CYC, 1, cycles cs+addr held after strobe (0 allowed).
- POLL_GAP, 4, idle cycles (cs low) between poll attempts (min 1).
- POLL_MAX, 255, max poll attempts before timeout (1..255).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  master idle, command accepted when cmd_valid&cmd_ready.
- cmd_op  in  2  00 write, 01 read, 10 poll, 11 illegal.
- cmd_addr  in  8  bus address.
- cmd_data  in  8  write data / poll match value.
- cmd_mask  in  8  poll compare mask.
- rsp_valid  out  1  one-cycle response pulse, no backpressure.
- rsp_data  out  8  read/poll data, 0 for write.
- rsp_err  out  1  poll timeout, illegal op or (optional) write-verify mismatch.
- busy  out  1  high whenever not IDLE.
- cs, rd, wr  out  1 each  bus strobes.
- addr, wdata  out  8 each  bus address / write data.
- rdata  in  8  bus read data.

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. All outputs are registered.
- Reset: all outputs 0; state IDLE. cmd_ready is 1 from the first cycle after rst deasserts.
- States and transitions: IDLE -> SETUP -> STROBE -> HOLD -> {RESP | GAP}. GAP -> SETUP. RESP -> IDLE.
- Zero-count states are skipped.
- IDLE: cmd_ready=1. On accept:
  - latch op/addr/data/mask;
  - drive addr=cmd_addr, wdata=cmd_data (write only, else 0), cs=1;
  - clear attempt counter.
- Cycle numbering: accept cycle = 0. SETUP = cycles 1..S. STROBE = S+1..S+T. HOLD = S+T+1..S+T+H. RESP = cycle S+T+H+1.
- Default timing: rsp_valid in cycle 4; next accept possible in cycle 5.
- STROBE: wr=1 for write, rd=1 for read/poll. rd and wr are never both high.
- rdata is sampled at the clock edge ending the last STROBE cycle.
- HOLD: rd=wr=0, cs=1, addr stable.
- After HOLD, by op:
  - write: RESP, rsp_data=0, rsp_err=0.
  - read: RESP, rsp_data=sample.
  - poll: increment attempts.
    - If (sample & mask)==(data & mask): RESP, err=0.
    - Else if attempts==POLL_MAX: RESP, err=1, rsp_data=last sample.
    - Else: GAP.
- GAP: cs=rd=wr=0, addr held; POLL_GAP cycles, then SETUP.
- RESP: cs=0, addr/wdata return to 0, rsp_valid=1 for one cycle, then IDLE.
- Illegal op 11: accepted, no bus activity, RESP in cycle 1 with err=1, data=0.
- mask=0x00 poll: matches on first attempt.
- cmd_valid while busy: ignored, cmd_ready=0. The command must be held by the source.
- rst mid-operation: strobes drop at that edge, no rsp_valid is issued, state IDLE.

Optional Feature:
- Macro FUZZY_BM_WRVERIFY_EN.
- Defined: after a write's HOLD, a read cycle of the same addr is run (SETUP/STROBE/HOLD with rd). RESP gives rsp_data=readback and rsp_err=(readback!=written data). Write response latency = 2*(S+T+H)+1.
- Undefined: writes complete as above and the verify logic is absent.

Test Plan:
- Reset, then write addr 0x10 data 0x5A (defaults):
  - cs high cycles 1-3, wr high only in cycle 2, addr=0x10, wdata=0x5A;
  - rsp_valid cycle 4 with err=0; cmd_ready high cycle 5.
- Read addr 0x20 with responder returning 0xC3, SETUP=2/STROBE=3/HOLD=0:
  - rd high cycles 3-5;
  - rsp_valid cycle 6, rsp_data=0xC3.
- Poll addr 0x01 match 0x01 mask 0x01, responder returns 0x00 twice then 0x81:
  - exactly 3 rd strobes, each separated by 4 cs-low cycles;
  - rsp_data=0x81, err=0.
- Poll with POLL_MAX=3, responder always 0x00:
  - 3 attempts, then rsp_err=1, rsp_data=0x00, back to IDLE.
- Illegal op 11 and rst asserted during STROBE of a write:
  - illegal op: no cs, rsp_valid cycle 1 with err=1;
  - reset case: wr low the cycle after the reset edge, no rsp_valid, cmd_ready=1 after release.
- With FUZZY_BM_WRVERIFY_EN, write 0x33 to a responder that reads back 0x32:
  - wr strobe followed by rd strobe to the same addr;
  - rsp_err=1, rsp_data=0x32.
